// File: rtl/tic_tac_toe_pkg.sv
// Shared cell/winner encodings and the win-line table for the tic-tac-toe core.
package tic_tac_toe_pkg;

   localparam int NUM_CELLS = 9;
   localparam int NUM_LINES = 8;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'b00,
      CELL_X     = 2'b01,
      CELL_O     = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_X    = 2'b01,
      WIN_O    = 2'b10,
      WIN_DRAW = 2'b11
   } winner_t;

   // Cell index triples of the three rows, three columns and two diagonals.
   localparam int WIN_LINES [NUM_LINES][3] = '{
      '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
      '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
      '{0, 4, 8}, '{2, 4, 6}
   };

   function automatic cell_t player_mark(input logic player);
      return player ? CELL_O : CELL_X;
   endfunction

   function automatic winner_t player_win(input logic player);
      return player ? WIN_O : WIN_X;
   endfunction

endpackage

// File: rtl/tic_tac_toe_win_detect.sv
// Combinational line/full detector over an 18-bit board (2 bits per cell, cell 0 in bits [1:0]).
module tic_tac_toe_win_detect
   import tic_tac_toe_pkg::*;
(
   input  logic [2*NUM_CELLS-1:0] board_i,
   output logic                   x_win_o,
   output logic                   o_win_o,
   output logic                   full_o
);

   always_comb begin
      // NOTE: every output gets a default before any conditional update, so no latch is inferred.
      x_win_o = 1'b0;
      o_win_o = 1'b0;
      full_o  = 1'b1;
      for (int l = 0; l < NUM_LINES; l++) begin
         if (board_i[2*WIN_LINES[l][0] +: 2] == CELL_X &&
             board_i[2*WIN_LINES[l][1] +: 2] == CELL_X &&
             board_i[2*WIN_LINES[l][2] +: 2] == CELL_X)
            x_win_o = 1'b1;
         if (board_i[2*WIN_LINES[l][0] +: 2] == CELL_O &&
             board_i[2*WIN_LINES[l][1] +: 2] == CELL_O &&
             board_i[2*WIN_LINES[l][2] +: 2] == CELL_O)
            o_win_o = 1'b1;
      end
      for (int c = 0; c < NUM_CELLS; c++) begin
         if (board_i[2*c +: 2] == CELL_EMPTY)
            full_o = 1'b0;
      end
   end

endmodule

// File: rtl/tic_tac_toe.sv
// Tic-tac-toe game core: board storage, move-request edge detect, validation and result registers.
module tic_tac_toe
   import tic_tac_toe_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cell_select,
   input  logic       place,
   output logic       current_player,
   output logic       game_over,
   output logic [1:0] winner
);

   logic [NUM_CELLS-1:0][1:0] board_q, board_d;
   logic                      place_q;
   logic                      player_q;
   logic                      over_q;
   winner_t                   winner_q;

   logic request, accept;
   logic x_win, o_win, full;

   assign request = place && !place_q;

   always_comb begin
      board_d = board_q;
      accept  = 1'b0;
      if (request && !over_q && (cell_select <= 4'd8)) begin
         if (board_q[cell_select] == CELL_EMPTY) begin
            accept                = 1'b1;
            board_d[cell_select]  = player_mark(player_q);
         end
      end
   end

   // Judged on the post-move board so the result lands on the same edge as the move.
   tic_tac_toe_win_detect u_win_detect (
      .board_i (board_d),
      .x_win_o (x_win),
      .o_win_o (o_win),
      .full_o  (full)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         board_q  <= '0;
         place_q  <= 1'b0;
         player_q <= 1'b0;
         over_q   <= 1'b0;
         winner_q <= WIN_NONE;
      end else begin
         place_q <= place;
         if (accept) begin
            board_q <= board_d;
            if (x_win || o_win) begin
               over_q   <= 1'b1;
               winner_q <= player_win(player_q);
            end else if (full) begin
               over_q   <= 1'b1;
               winner_q <= WIN_DRAW;
            end else begin
               player_q <= !player_q;
            end
         end
      end
   end

   assign current_player = player_q;
   assign game_over      = over_q;
   assign winner         = winner_q;

endmodule

// File: tb/tb_tic_tac_toe.sv
// Directed-vector bench for the tic-tac-toe core; inputs driven and outputs sampled on the falling edge.
module tb_tic_tac_toe;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] cell_select = 4'd0;
   logic       place = 1'b0;
   logic       current_player;
   logic       game_over;
   logic [1:0] winner;

   int errors = 0;
   int checks = 0;

   tic_tac_toe dut (
      .clk            (clk),
      .reset          (reset),
      .cell_select    (cell_select),
      .place          (place),
      .current_player (current_player),
      .game_over      (game_over),
      .winner         (winner)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      place = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] c);
      @(negedge clk);
      cell_select = c;
      place = 1'b1;
      @(negedge clk);
      place = 1'b0;
   endtask

   task automatic expect_state(input string name, input logic exp_cp,
                               input logic exp_over, input logic [1:0] exp_win);
      checks++;
      if (current_player !== exp_cp) begin
         errors++;
         $display("FAIL %s current_player got %b want %b", name, current_player, exp_cp);
      end
      checks++;
      if (game_over !== exp_over) begin
         errors++;
         $display("FAIL %s game_over got %b want %b", name, game_over, exp_over);
      end
      checks++;
      if (winner !== exp_win) begin
         errors++;
         $display("FAIL %s winner got %b want %b", name, winner, exp_win);
      end
   endtask

   task automatic test_reset();
      do_reset();
      expect_state("reset", 1'b0, 1'b0, 2'b00);
   endtask

   task automatic test_row_win();
      do_reset();
      pulse(0); expect_state("row_x0", 1'b1, 1'b0, 2'b00);
      pulse(3); pulse(1); pulse(4);
      expect_state("row_4moves", 1'b0, 1'b0, 2'b00);
      pulse(2); expect_state("row_win", 1'b0, 1'b1, 2'b01);
   endtask

   task automatic test_col_win();
      do_reset();
      pulse(0); pulse(1); pulse(3); pulse(4); pulse(8);
      expect_state("col_5moves", 1'b1, 1'b0, 2'b00);
      pulse(7); expect_state("col_o_win", 1'b1, 1'b1, 2'b10);
   endtask

   task automatic test_draw();
      do_reset();
      pulse(0); pulse(1); pulse(2); pulse(4); pulse(3);
      pulse(5); pulse(7); pulse(6);
      expect_state("draw_8moves", 1'b0, 1'b0, 2'b00);
      pulse(8); expect_state("draw", 1'b0, 1'b1, 2'b11);
   endtask

   task automatic test_win_on_ninth();
      do_reset();
      pulse(0); pulse(1); pulse(2); pulse(3); pulse(4);
      pulse(5); pulse(7); pulse(6);
      expect_state("ninth_8moves", 1'b0, 1'b0, 2'b00);
      pulse(8); expect_state("ninth_win", 1'b0, 1'b1, 2'b01);
   endtask

   task automatic test_invalid();
      do_reset();
      pulse(4); expect_state("inv_x4", 1'b1, 1'b0, 2'b00);
      pulse(4); expect_state("inv_occupied", 1'b1, 1'b0, 2'b00);
      for (int c = 9; c <= 15; c++) pulse(4'(c));
      expect_state("inv_range", 1'b1, 1'b0, 2'b00);
      // X must still own cell 4: finishing the 2-4-6 diagonal proves it.
      pulse(0); pulse(2); pulse(1);
      expect_state("inv_cont", 1'b0, 1'b0, 2'b00);
      pulse(6); expect_state("inv_diag", 1'b0, 1'b1, 2'b01);
   endtask

   task automatic test_hold_and_freeze();
      do_reset();
      @(negedge clk);
      cell_select = 4'd0;
      place = 1'b1;
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         cell_select = 4'(i + 4);
      end
      @(negedge clk);
      place = 1'b0;
      expect_state("hold_one_move", 1'b1, 1'b0, 2'b00);
      pulse(3); pulse(1); pulse(4); pulse(2);
      expect_state("hold_win", 1'b0, 1'b1, 2'b01);
      pulse(5); pulse(6); pulse(8);
      expect_state("frozen", 1'b0, 1'b1, 2'b01);
   endtask

   task automatic test_mid_reset();
      do_reset();
      pulse(0); pulse(4);
      @(negedge clk);
      reset = 1'b1;
      cell_select = 4'd2;
      place = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      place = 1'b0;
      expect_state("mid_reset", 1'b0, 1'b0, 2'b00);
      // Previously occupied cells and the cell requested during reset must be free.
      pulse(4); expect_state("post_rst_4", 1'b1, 1'b0, 2'b00);
      pulse(0); expect_state("post_rst_0", 1'b0, 1'b0, 2'b00);
      pulse(2); expect_state("post_rst_2", 1'b1, 1'b0, 2'b00);
   endtask

   initial begin
      test_reset();
      test_row_win();
      test_col_win();
      test_draw();
      test_win_on_ninth();
      test_invalid();
      test_hold_and_freeze();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
